// File: rtl/motor_position_controller_if.sv
// motor_position_controller_if
//   Command bus between the host/command logic and the position controller.
//   master : host side (drives target/req/abort, observes handshake + status)
//   slave  : controller side
//   Signals: target[11:0], req, abort, ack, nack, busy, done, fault.
interface motor_position_controller_if;
  logic [11:0] target;
  logic        req;
  logic        abort;
  logic        ack;
  logic        nack;
  logic        busy;
  logic        done;
  logic        fault;

  modport master (output target, req, abort, input ack, nack, busy, done, fault);
  modport slave  (input target, req, abort, output ack, nack, busy, done, fault);
endinterface

// File: rtl/motor_position_controller.sv
// motor_position_controller
//   Closed-loop position sequencer. Takes a target angle over req/ack, picks
//   the shortest direction around the 0..COUNTS_PER_REV-1 ring, drives the
//   motor with fast/slow PWM duty, settles with the motor off, then re-plans
//   or reports done.
// Ports:
//   CLK        system clock (rising edge)
//   reset      asynchronous, active-high
//   cmd        command bus (slave): target, req, abort -> ack, nack, busy,
//              done, fault
//   angle      current angle from the angle tracking unit (CLK domain)
//   motor_en   PWM enable to the motor driver
//   clockwise  direction to the motor driver and ATU
//   monitor    ATU monitor enable, high from the first edge after reset
// Build option:
//   POS_CTRL_STALL_TIMEOUT_EN - adds a stall timer in MOVE that raises the
//   sticky fault flag and returns to IDLE; without it fault is tied low.
module motor_position_controller #(
  parameter int COUNTS_PER_REV = 1006,
  parameter int TOLERANCE      = 2,
  parameter int SLOW_ZONE      = 50,
  parameter int PWM_PERIOD     = 1000,
  parameter int DUTY_FAST      = 900,
  parameter int DUTY_SLOW      = 300,
  parameter int SETTLE_CYCLES  = 100000,
  parameter int STALL_CYCLES   = 5000000
) (
  input  logic                         CLK,
  input  logic                         reset,
  motor_position_controller_if.slave   cmd,
  input  logic [11:0]                  angle,
  output logic                         motor_en,
  output logic                         clockwise,
  output logic                         monitor
);

  typedef enum logic [2:0] {IDLE, PLAN, MOVE, SETTLE, DONE} state_t;

  localparam int PWM_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);
  localparam logic [PWM_W:0]   DUTY_F   = (PWM_W+1)'(DUTY_FAST);
  localparam logic [PWM_W:0]   DUTY_S   = (PWM_W+1)'(DUTY_SLOW);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [12:0]      CPR13    = 13'(COUNTS_PER_REV);
  localparam logic [12:0]      HALF13   = 13'(COUNTS_PER_REV / 2);
  localparam logic [12:0]      TOL13    = 13'(TOLERANCE);
  localparam logic [12:0]      SLOW13   = 13'(SLOW_ZONE);
  localparam logic [11:0]      CPR12    = 12'(COUNTS_PER_REV);

  // Clockwise distance from a to t on the ring. A negative 13-bit
  // difference is folded back by adding one revolution.
  function automatic logic [12:0] cw_dist(input logic [11:0] t, input logic [11:0] a);
    logic [12:0] d;
    d = {1'b0, t} - {1'b0, a};
    if (d[12]) d = d + CPR13;
    return d;
  endfunction

  state_t           state, state_n;
  logic [11:0]      tgt_q, tgt_n;
  logic [PWM_W-1:0] pwm_cnt, pwm_n, pwm_inc;
  logic [SET_W-1:0] settle_cnt, settle_n;
  logic             ack_q, nack_q, done_q, busy_q;
  logic             ack_n, nack_n, en_n, cw_n;
  logic             clr_fault;

  logic [12:0]      cw_d, ccw_d, err, rem;
  logic             cw_short;
  logic [PWM_W:0]   duty, duty_plan;

  assign cw_d      = cw_dist(tgt_q, angle);
  assign ccw_d     = (cw_d == 13'd0) ? 13'd0 : CPR13 - cw_d;
  assign cw_short  = (cw_d <= ccw_d);                 // tie goes clockwise
  assign err       = cw_short ? cw_d : ccw_d;
  assign rem       = clockwise ? cw_d : ccw_d;         // distance along chosen direction
  assign duty      = (rem <= SLOW13) ? DUTY_S : DUTY_F;
  assign duty_plan = (err <= SLOW13) ? DUTY_S : DUTY_F;
  assign pwm_inc   = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;

`ifdef POS_CTRL_STALL_TIMEOUT_EN
  localparam int STL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'(STALL_CYCLES - 1);

  logic [11:0]      angle_q;
  logic [STL_W-1:0] stall_cnt;
  logic             fault_q, stall_hit;

  // Counts consecutive MOVE cycles with an unchanged angle; any change or
  // leaving MOVE restarts it.
  assign stall_hit = (state == MOVE) && (angle == angle_q) && (stall_cnt == STL_LAST);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      angle_q   <= '0;
      stall_cnt <= '0;
      fault_q   <= 1'b0;
    end else begin
      angle_q   <= angle;
      stall_cnt <= ((state == MOVE) && (angle == angle_q)) ? stall_cnt + 1'b1 : '0;
      if (clr_fault)      fault_q <= 1'b0;
      else if (stall_hit) fault_q <= 1'b1;
    end
  end

  assign cmd.fault = fault_q;
`else
  assign cmd.fault = 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tgt_n     = tgt_q;
    pwm_n     = pwm_cnt;
    settle_n  = '0;
    ack_n     = 1'b0;
    nack_n    = 1'b0;
    en_n      = 1'b0;
    cw_n      = clockwise;
    clr_fault = 1'b0;

    case (state)
      IDLE: begin
        if (cmd.req) begin
          if (cmd.target < CPR12) begin
            tgt_n     = cmd.target;
            ack_n     = 1'b1;
            clr_fault = 1'b1;
            state_n   = PLAN;
          end else begin
            nack_n = 1'b1;
          end
        end
      end
      PLAN: begin
        if (err <= TOL13) begin
          state_n = DONE;
        end else begin
          // Direction only changes here, with the motor already off.
          cw_n    = cw_short;
          pwm_n   = '0;
          en_n    = (duty_plan != '0);
          state_n = MOVE;
        end
      end
      MOVE: begin
        // Past HALF means we overshot and the directional distance wrapped.
        if ((rem <= TOL13) || (rem > HALF13)) begin
          state_n = SETTLE;
        end else begin
          pwm_n = pwm_inc;
          en_n  = ({1'b0, pwm_inc} < duty);
        end
      end
      SETTLE: begin
        if (settle_cnt == SET_LAST) state_n = (err <= TOL13) ? DONE : PLAN;
        else                        settle_n = settle_cnt + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (cmd.abort && (state == PLAN || state == MOVE || state == SETTLE)) begin
      state_n = IDLE;
      en_n    = 1'b0;
      cw_n    = clockwise;
    end

`ifdef POS_CTRL_STALL_TIMEOUT_EN
    if (stall_hit) begin
      state_n = IDLE;
      en_n    = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      tgt_q      <= '0;
      pwm_cnt    <= '0;
      settle_cnt <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      motor_en   <= 1'b0;
      clockwise  <= 1'b1;
      monitor    <= 1'b0;
    end else begin
      tgt_q      <= tgt_n;
      pwm_cnt    <= pwm_n;
      settle_cnt <= settle_n;
      ack_q      <= ack_n;
      nack_q     <= nack_n;
      done_q     <= (state_n == DONE);
      busy_q     <= (state_n != IDLE);
      motor_en   <= en_n;
      clockwise  <= cw_n;
      monitor    <= 1'b1;
    end
  end

  assign cmd.ack  = ack_q;
  assign cmd.nack = nack_q;
  assign cmd.done = done_q;
  assign cmd.busy = busy_q;

endmodule

// File: tb/tb_motor_position_controller.sv
module tb_motor_position_controller;

  logic        CLK;
  logic        reset;
  logic [11:0] angle;
  logic        motor_en, clockwise, monitor;

  logic        load_en;
  logic [11:0] load_val;
  logic        freeze;

  int n_assert;
  int n_fail;

  motor_position_controller_if cmd ();

  motor_position_controller #(
    .COUNTS_PER_REV(1006), .TOLERANCE(2), .SLOW_ZONE(50),
    .PWM_PERIOD(10), .DUTY_FAST(9), .DUTY_SLOW(3),
    .SETTLE_CYCLES(20), .STALL_CYCLES(200)
  ) dut (
    .CLK(CLK), .reset(reset), .cmd(cmd), .angle(angle),
    .motor_en(motor_en), .clockwise(clockwise), .monitor(monitor)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Motor + ATU: one count per cycle while enabled, wrapping on the ring.
  always @(posedge CLK) begin
    if (load_en)                angle <= load_val;
    else if (!freeze && motor_en)
      angle <= clockwise ? ((angle == 12'd1005) ? 12'd0 : angle + 12'd1)
                         : ((angle == 12'd0) ? 12'd1005 : angle - 12'd1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ring_err(input int a, input int t);
    int d;
    d = (t - a + 1006) % 1006;
    return (d <= 503) ? d : 1006 - d;
  endfunction

  task automatic set_angle(input int v);
    load_val = 12'(v);
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
  endtask

  // Issue a request and step through the ack edge and the PLAN edge.
  task automatic start_move(input int a, input int t, input string tag);
    set_angle(a);
    cmd.target = 12'(t);
    cmd.req    = 1'b1;
    tick();
    chk({tag, "_ack"}, int'(cmd.ack), 1);
    chk({tag, "_busy"}, int'(cmd.busy), 1);
    cmd.req = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int t, input string tag);
    int got;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cmd.done) begin got = 1; break; end
      tick();
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_final_err_ok"}, int'(ring_err(int'(angle), t) <= 2), 1);
    chk({tag, "_busy_at_done"}, int'(cmd.busy), 1);
    tick();
    chk({tag, "_done_one_cycle"}, int'(cmd.done), 0);
    chk({tag, "_busy_after"}, int'(cmd.busy), 0);
  endtask

  task automatic run_move(input int a, input int t, input int exp_cw, input string tag);
    start_move(a, t, tag);
    chk({tag, "_en_first"}, int'(motor_en), 1);
    chk({tag, "_dir"}, int'(clockwise), exp_cw);
    wait_done(t, tag);
  endtask

  initial begin
    int hi, got, saw;
    n_assert   = 0;
    n_fail     = 0;
    load_en    = 1'b0;
    load_val   = '0;
    freeze     = 1'b0;
    angle      = '0;
    cmd.req    = 1'b0;
    cmd.abort  = 1'b0;
    cmd.target = '0;
    reset      = 1'b1;
    repeat (3) tick();

    chk("rst_motor_en", int'(motor_en), 0);
    chk("rst_busy", int'(cmd.busy), 0);
    chk("rst_clockwise", int'(clockwise), 1);
    chk("rst_monitor", int'(monitor), 0);
    chk("rst_ack", int'(cmd.ack), 0);
    chk("rst_nack", int'(cmd.nack), 0);
    chk("rst_done", int'(cmd.done), 0);
    chk("rst_fault", int'(cmd.fault), 0);

    reset = 1'b0;
    tick();
    chk("monitor_on", int'(monitor), 1);

    // 100 -> 300: fast duty, then slow from 250, then settle and done.
    set_angle(100);
    cmd.target = 12'd300;
    cmd.req    = 1'b1;
    tick();
    chk("m1_ack", int'(cmd.ack), 1);
    chk("m1_busy", int'(cmd.busy), 1);
    chk("m1_en_at_ack", int'(motor_en), 0);
    cmd.req = 1'b0;
    tick();
    chk("m1_en_first", int'(motor_en), 1);
    chk("m1_dir", int'(clockwise), 1);
    chk("m1_ack_pulse", int'(cmd.ack), 0);
    hi = 0;
    repeat (10) begin hi += int'(motor_en); tick(); end
    chk("m1_fast_duty", hi, 9);
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      if (angle >= 12'd255) begin got = 1; break; end
      tick();
    end
    chk("m1_reach_slow", got, 1);
    hi = 0;
    repeat (10) begin hi += int'(motor_en); tick(); end
    chk("m1_slow_duty", hi, 3);
    wait_done(300, "m1");
    chk("m1_angle_window", int'(angle >= 12'd298 && angle <= 12'd302), 1);

    run_move(1000, 10, 1, "wrap_cw");
    run_move(10, 1000, 0, "wrap_ccw");
    run_move(0, 503, 1, "tie");

    // Already within tolerance: done straight from PLAN, motor never on.
    set_angle(400);
    cmd.target = 12'd401;
    cmd.req    = 1'b1;
    tick();
    chk("tol_ack", int'(cmd.ack), 1);
    chk("tol_en0", int'(motor_en), 0);
    cmd.req = 1'b0;
    tick();
    chk("tol_done", int'(cmd.done), 1);
    chk("tol_en1", int'(motor_en), 0);
    tick();
    chk("tol_done_end", int'(cmd.done), 0);
    chk("tol_idle", int'(cmd.busy), 0);

    // Out-of-range target.
    cmd.target = 12'd1006;
    cmd.req    = 1'b1;
    tick();
    chk("nack_pulse", int'(cmd.nack), 1);
    chk("nack_no_ack", int'(cmd.ack), 0);
    chk("nack_busy", int'(cmd.busy), 0);
    cmd.req = 1'b0;
    tick();
    chk("nack_end", int'(cmd.nack), 0);

    // req while busy is ignored; abort stops the motor on the next edge.
    start_move(100, 600, "abt");
    repeat (5) tick();
    cmd.target = 12'd50;
    cmd.req    = 1'b1;
    saw = 0;
    repeat (3) begin tick(); saw |= int'(cmd.ack | cmd.nack); end
    chk("busy_req_ignored", saw, 0);
    cmd.req = 1'b0;
    tick();
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (motor_en) begin got = 1; break; end
      tick();
    end
    chk("abt_en_before", got, 1);
    cmd.abort = 1'b1;
    tick();
    cmd.abort = 1'b0;
    chk("abt_en_off", int'(motor_en), 0);
    chk("abt_idle", int'(cmd.busy), 0);
    saw = 0;
    repeat (25) begin saw |= int'(cmd.done); tick(); end
    chk("abt_no_done", saw, 0);

    // Frozen angle during MOVE.
    freeze = 1'b1;
    start_move(100, 600, "stall");
`ifdef POS_CTRL_STALL_TIMEOUT_EN
    repeat (150) tick();
    chk("stall_early_fault", int'(cmd.fault), 0);
    chk("stall_early_busy", int'(cmd.busy), 1);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (cmd.fault) begin got = 1; break; end
      tick();
    end
    chk("stall_fault", got, 1);
    chk("stall_en_off", int'(motor_en), 0);
    chk("stall_idle", int'(cmd.busy), 0);
`else
    repeat (300) tick();
    chk("nostall_fault", int'(cmd.fault), 0);
    chk("nostall_busy", int'(cmd.busy), 1);
    cmd.abort = 1'b1;
    tick();
    cmd.abort = 1'b0;
    chk("nostall_abort", int'(cmd.busy), 0);
`endif
    freeze = 1'b0;

    // Asynchronous reset mid-move while turning counter-clockwise.
    start_move(150, 0, "rstmv");
    chk("rstmv_dir", int'(clockwise), 0);
    chk("rstmv_fault_clear", int'(cmd.fault), 0);
    repeat (3) tick();
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (motor_en) begin got = 1; break; end
      tick();
    end
    chk("rstmv_en_before", got, 1);
    #3 reset = 1'b1;
    #1;
    chk("rstmv_en", int'(motor_en), 0);
    chk("rstmv_busy", int'(cmd.busy), 0);
    chk("rstmv_dir_rst", int'(clockwise), 1);
    chk("rstmv_monitor", int'(monitor), 0);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_position_controller.md
# motor_position_controller

Closed-loop position sequencer for the hall-sensor motor. Accepts a target angle over a req/ack handshake, reads the live count from the angle tracking unit, and drives the motor driver's enable (PWM) and direction lines. It takes the shortest path around the 0..COUNTS_PER_REV-1 ring, slows near the target, settles, and re-plans if the settled error is outside tolerance. It sits between the host/command logic and the angle_tracking_unit / motor driver pair, and owns the ATU's `clockwise` and `monitor` inputs.

## Interface
- COUNTS_PER_REV, 1006, counts per revolution; angle range 0..COUNTS_PER_REV-1
- TOLERANCE, 2, max |error| in counts accepted as on-target
- SLOW_ZONE, 50, remaining distance at or below which slow duty is used
- PWM_PERIOD, 1000, PWM period in CLK cycles
- DUTY_FAST, 900, high cycles per period when far from target
- DUTY_SLOW, 300, high cycles per period inside SLOW_ZONE
- SETTLE_CYCLES, 100000, motor-off wait before error re-check
- STALL_CYCLES, 5000000, MOVE cycles with unchanged angle before fault (macro only)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- target  in  12  requested angle, sampled when req accepted
- req  in  1  move request; held by requester until ack or nack
- ack  out  1  one-cycle pulse: request accepted
- nack  out  1  one-cycle pulse: request rejected (target >= COUNTS_PER_REV)
- abort  in  1  stop current move, return to IDLE
- angle  in  12  current angle from angle_tracking_unit
- motor_en  out  1  PWM enable to motor driver
- clockwise  out  1  direction to motor driver and ATU
- monitor  out  1  ATU monitor enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: target reached
- fault  out  1  sticky stall flag

## Operation
- States: IDLE, PLAN, MOVE, SETTLE, DONE.
- IDLE: motor_en=0. If req=1 and target<COUNTS_PER_REV: latch target, pulse ack, -> PLAN, clear fault. If target is out of range: pulse nack, stay in IDLE. req while busy is ignored (no ack/nack).
- PLAN (1 cycle): cw = (target - angle) mod COUNTS_PER_REV; ccw = COUNTS_PER_REV - cw (ccw = 0 when cw = 0). If min(cw,ccw) <= TOLERANCE -> DONE. Otherwise clockwise = (cw <= ccw), so a tie goes clockwise, and -> MOVE with the PWM counter cleared.
- MOVE: remaining = directional distance (cw if clockwise, else ccw), recomputed every cycle with 13-bit arithmetic and modular correction. motor_en = (pwm_cnt < duty); duty = DUTY_SLOW if remaining <= SLOW_ZONE, else DUTY_FAST. pwm_cnt wraps at PWM_PERIOD-1. If remaining <= TOLERANCE, or remaining > COUNTS_PER_REV/2 (overshoot wrapped), -> SETTLE.
- SETTLE: motor_en=0; count SETTLE_CYCLES, then recompute min(cw,ccw). If <= TOLERANCE -> DONE, else -> PLAN. Retries are unlimited.
- DONE: pulse done, -> IDLE.
- abort=1 in PLAN/MOVE/SETTLE: motor_en=0 on the next edge, -> IDLE, no done. abort in IDLE has no effect.
- clockwise changes only in PLAN, when motor_en is already 0.
- monitor = 1 from the first edge after reset is released.

## Timing
- Reset values: ack=0, nack=0, done=0, busy=0, motor_en=0, clockwise=1, monitor=0, fault=0, state=IDLE. Reset mid-move stops the motor immediately (asynchronous).
- All outputs are registered. ack/nack assert on the edge after req is sampled high; busy rises on the same edge as ack.
- Request to first motor_en high: 2 cycles (ack edge, PLAN edge).
- done asserts for exactly one cycle; busy falls on the same edge that done falls.
- angle is treated as synchronous to CLK; the ATU output is already registered in the same domain.

## Configuration
- POS_CTRL_STALL_TIMEOUT_EN defined: a counter reloads on every change of angle during MOVE. When it reaches STALL_CYCLES: motor_en=0, fault=1 (sticky until the next accepted req), -> IDLE, no done.
- Not defined: no stall counter; fault is tied to 0; STALL_CYCLES is unused.

## Test plan
Bench uses PWM_PERIOD=10, SETTLE_CYCLES=20, STALL_CYCLES=200 and a behavioural motor+ATU model.
- Reset during MOVE at angle 150 -> motor_en=0, busy=0, clockwise=1, monitor=0 without waiting for a CLK edge.
- angle=100, req target=300 -> ack after 1 cycle, clockwise=1, duty 9/10 then 3/10 from angle 250; done once angle is in 298..302 after settle.
- Wrap: angle=1000, target=10 -> clockwise=1, stops near 10. angle=10, target=1000 -> clockwise=0.
- Tie: angle=0, target=503 -> clockwise=1. Target already within tolerance (angle=400, target=401) -> done with motor_en never high.
- target=1006 -> nack pulse, busy stays 0. req during MOVE -> no ack. abort during MOVE -> motor_en=0 next cycle, IDLE, no done.
- Angle frozen during MOVE: with macro, fault=1 and motor_en=0 after 200 cycles. Without macro, fault stays 0 and the motor remains in MOVE.
